// File: rtl/deinterleaver_pkg.sv
// Shared geometry of the convolutional interleaver/deinterleaver pair.
// Both ends import this so branch lengths and memory bases always agree.
package deinterleaver_pkg;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_BRANCHES = 12;
   localparam int DEF_M        = 17;

   // Deinterleaver branch k holds (BRANCHES-1-k)*M entries; the last branch is empty.
   function automatic int branch_len(input int branches, input int m, input int k);
      return (branches - 1 - k) * m;
   endfunction

   function automatic int branch_base(input int branches, input int m, input int k);
      int s = 0;
      for (int j = 0; j < k; j++) s += branch_len(branches, m, j);
      return s;
   endfunction

   function automatic int total_mem(input int branches, input int m);
      return m * branches * (branches - 1) / 2;
   endfunction

   localparam int DEF_TOTAL_MEM = total_mem(DEF_BRANCHES, DEF_M);
endpackage

// File: rtl/deint_delay_mem.sv
// Flat delay-line storage for all branches: combinational read, clocked write,
// so a read and write at the same address return the old byte.
module deint_delay_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1122,
   parameter int AW    = 11
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
endmodule

// File: rtl/deinterleaver.sv
// Convolutional byte deinterleaver: branch counter, per-branch ring pointers,
// 1-deep output register with rdy/acpt handshake, and a priming counter.
module deinterleaver
   import deinterleaver_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int BRANCHES = DEF_BRANCHES,
   parameter int M        = DEF_M
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             di_rdy,
   output logic             di_acpt,
   input  logic [WIDTH-1:0] di_data,
   output logic             do_rdy,
   input  logic             do_acpt,
   output logic [WIDTH-1:0] do_data,
   input  logic             enable,
   output logic             primed
);
   localparam int DEPTH   = total_mem(BRANCHES, M);
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW      = (BRANCHES > 1) ? $clog2(BRANCHES) : 1;
   localparam int PRIME_N = BRANCHES * (BRANCHES - 1) * M;
   localparam int CW      = $clog2(PRIME_N + 1);

   logic [BW-1:0]    r_branch;
   logic             r_do_rdy;
   logic [WIDTH-1:0] r_do_data;
   logic [CW-1:0]    r_prime_cnt;
   logic             w_in_xfer;
   logic             w_last;
   logic             w_primed;
   logic [AW-1:0]    w_addr;
   logic [AW-1:0]    w_addr_br [BRANCHES-1];
   logic [WIDTH-1:0] w_rd_data;

   // reset_n gates acceptance so di_acpt reads 0 for the whole reset window
   assign di_acpt   = reset_n & enable & (~r_do_rdy | do_acpt);
   assign w_in_xfer = di_rdy & di_acpt;
   assign w_last    = (r_branch == BW'(BRANCHES - 1));
   assign w_primed  = (r_prime_cnt == CW'(PRIME_N));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_branch <= '0;
      else if (w_in_xfer) r_branch <= w_last ? '0 : r_branch + 1'b1;
   end

   for (genvar k = 0; k < BRANCHES - 1; k++) begin : g_br
      localparam int LEN  = branch_len(BRANCHES, M, k);
      localparam int BASE = branch_base(BRANCHES, M, k);
      localparam int PW   = (LEN > 1) ? $clog2(LEN) : 1;
      logic [PW-1:0] r_ptr;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            r_ptr <= '0;
         else if (w_in_xfer && r_branch == BW'(k))
            r_ptr <= (r_ptr == PW'(LEN - 1)) ? '0 : r_ptr + 1'b1;
      end

      assign w_addr_br[k] = AW'(BASE) + AW'(r_ptr);
   end

   always_comb begin
      w_addr = '0;
      for (int k = 0; k < BRANCHES - 1; k++)
         if (r_branch == BW'(k)) w_addr = w_addr_br[k];
   end

   deint_delay_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .i_we    (w_in_xfer & ~w_last),
      .i_addr  (w_addr),
      .i_wdata (di_data),
      .o_rdata (w_rd_data)
   );

   // Output only loads on input xfer, so it holds while stalled downstream
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_do_rdy  <= 1'b0;
         r_do_data <= '0;
      end else if (w_in_xfer) begin
         r_do_rdy  <= 1'b1;
         r_do_data <= w_last ? di_data : w_rd_data;
      end else if (do_acpt) begin
         r_do_rdy  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    r_prime_cnt <= '0;
      else if (w_in_xfer && !w_primed) r_prime_cnt <= r_prime_cnt + 1'b1;
   end

   assign do_rdy  = r_do_rdy;
   assign do_data = r_do_data;
   assign primed  = w_primed;
endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench for deinterleaver: standalone history model and an
// interleaver-chained model, plus backpressure, enable and reset scenarios.
module tb_deinterleaver;
   localparam int NB  = 12;
   localparam int MM  = 17;
   localparam int DLY = NB * (NB - 1) * MM;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       di_rdy = 1'b0;
   logic       do_acpt = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] di_data = 8'h00;
   logic       di_acpt, do_rdy, primed;
   logic [7:0] do_data;

   typedef struct {
      bit         chk;
      logic [7:0] val;
      int         idx;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] hist[4096];
   logic [7:0] out_log[4096];
   logic [7:0] src[4096];
   logic [7:0] ilv[4096];
   int n_in = 0, n_out = 0, mode = 0;
   int errors = 0, checks = 0;

   deinterleaver dut (
      .clk     (clk),
      .reset_n (reset_n),
      .di_rdy  (di_rdy),
      .di_acpt (di_acpt),
      .di_data (di_data),
      .do_rdy  (do_rdy),
      .do_acpt (do_acpt),
      .do_data (do_data),
      .enable  (enable),
      .primed  (primed)
   );

   always #5 clk = ~clk;

   // One clock: sample handshakes just after the falling edge, log transfers.
   task automatic step();
      exp_t e;
      int k, d;
      #1;
      if (di_rdy && di_acpt) begin
         hist[n_in] = di_data;
         e.idx = n_in; e.chk = 1'b0; e.val = 8'h00;
         if (mode == 0) begin
            k = n_in % NB;
            d = NB * (NB - 1 - k) * MM;
            if (n_in >= d) begin e.chk = 1'b1; e.val = hist[n_in - d]; end
         end else if (n_in >= DLY) begin
            e.chk = 1'b1; e.val = src[n_in - DLY];
         end
         exp_q.push_back(e);
         n_in++;
      end
      if (do_rdy && do_acpt) begin
         got_q.push_back(do_data);
         out_log[n_out] = do_data;
         n_out++;
      end
      @(negedge clk);
   endtask

   function automatic bit sb_pop(output exp_t e, output logic [7:0] g);
      if (exp_q.size() == 0 || got_q.size() == 0) return 1'b0;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      return 1'b1;
   endfunction

   task automatic sb_clear();
      exp_q.delete(); got_q.delete();
      n_in = 0; n_out = 0;
   endtask

   task automatic build_chain();
      int p, o, k, d;
      for (int n = 0; n < 4096; n++) begin
         p = n / 204; o = n % 204;
         src[n] = (o == 0) ? ((p % 8 == 0) ? 8'hB8 : 8'h47) : 8'($urandom);
      end
      for (int n = 0; n < 4096; n++) begin
         k = n % NB; d = NB * k * MM;
         ilv[n] = (n >= d) ? src[n - d] : 8'h00;
      end
   endtask

   task automatic test_reset();
      enable = 1'b1; do_acpt = 1'b1; di_rdy = 1'b1; reset_n = 1'b0;
      #1;
      checks++; if (do_rdy !== 1'b0) begin errors++; $display("FAIL reset_do_rdy got=%b exp=0", do_rdy); end
      checks++; if (di_acpt !== 1'b0) begin errors++; $display("FAIL reset_di_acpt got=%b exp=0", di_acpt); end
      checks++; if (do_data !== 8'h00) begin errors++; $display("FAIL reset_do_data got=%h exp=00", do_data); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed got=%b exp=0", primed); end
      di_rdy = 1'b0;
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      sb_clear();
      #1;
      checks++; if (di_acpt !== 1'b1) begin errors++; $display("FAIL post_reset_di_acpt got=%b exp=1", di_acpt); end
   endtask

   task automatic test_passthrough();
      exp_t e; logic [7:0] g;
      mode = 0; do_acpt = 1'b1; di_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin di_data = 8'(i); step(); end
      checks++; if (n_in !== 12) begin errors++; $display("FAIL pt_accepted got=%0d exp=12", n_in); end
      checks++; if (do_rdy !== 1'b1) begin errors++; $display("FAIL pt_do_rdy got=%b exp=1", do_rdy); end
      checks++; if (do_data !== 8'h0B) begin errors++; $display("FAIL pt_do_data got=%h exp=0b", do_data); end
      di_rdy = 1'b0;
      repeat (3) step();
      while (sb_pop(e, g)) if (e.chk) begin
         checks++;
         if (g !== e.val) begin errors++; $display("FAIL sb_pt idx=%0d got=%h exp=%h", e.idx, g, e.val); end
      end
   endtask

   task automatic test_stream();
      exp_t e; logic [7:0] g;
      reset_n = 1'b0; #1; @(negedge clk); reset_n = 1'b1; sb_clear();
      mode = 0; do_acpt = 1'b1; di_rdy = 1'b1;
      for (int c = 0; c < 3000 && n_in < 2400; c++) begin
         di_data = 8'(n_in + 1);
         step();
         if (n_in == DLY - 1) begin
            checks++; if (primed !== 1'b0) begin errors++; $display("FAIL primed_early got=%b exp=0", primed); end
         end
         if (n_in == DLY) begin
            checks++; if (primed !== 1'b1) begin errors++; $display("FAIL primed_rise got=%b exp=1", primed); end
         end
         while (sb_pop(e, g)) if (e.chk) begin
            checks++;
            if (g !== e.val) begin errors++; $display("FAIL sb_stream idx=%0d got=%h exp=%h", e.idx, g, e.val); end
         end
      end
      checks++; if (n_in < 2400) begin errors++; $display("FAIL stream_timeout got=%0d exp=2400", n_in); end
      checks++; if (out_log[214] !== 8'd11) begin errors++; $display("FAIL out214 got=%h exp=0b", out_log[214]); end
      checks++; if (out_log[DLY] !== 8'd1) begin errors++; $display("FAIL out2244 got=%h exp=01", out_log[DLY]); end
   endtask

   task automatic test_backpressure();
      exp_t e; logic [7:0] g; logic [7:0] held;
      int target;
      do_acpt = 1'b0; di_rdy = 1'b1; di_data = 8'(n_in + 1);
      held = do_data;
      checks++; if (do_rdy !== 1'b1) begin errors++; $display("FAIL bp_pending got=%b exp=1", do_rdy); end
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++; if (di_acpt !== 1'b0) begin errors++; $display("FAIL bp_di_acpt cyc=%0d got=%b exp=0", i, di_acpt); end
         checks++; if (do_data !== held || do_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", i, do_data, do_rdy, held);
         end
         step();
      end
      do_acpt = 1'b1; target = n_in + 50;
      for (int c = 0; c < 200 && n_in < target; c++) begin di_data = 8'(n_in + 1); step(); end
      di_rdy = 1'b0;
      repeat (3) step();
      while (sb_pop(e, g)) if (e.chk) begin
         checks++;
         if (g !== e.val) begin errors++; $display("FAIL sb_bp idx=%0d got=%h exp=%h", e.idx, g, e.val); end
      end
      checks++; if (n_out !== n_in || exp_q.size() != 0 || got_q.size() != 0) begin
         errors++; $display("FAIL bp_count got=%0d outs exp=%0d", n_out, n_in);
      end
   endtask

   task automatic test_enable();
      exp_t e; logic [7:0] g;
      int n_before, target;
      di_rdy = 1'b1; do_acpt = 1'b1;
      repeat (20) begin di_data = 8'(n_in + 1); step(); end
      enable = 1'b0; n_before = n_in;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (di_acpt !== 1'b0) begin errors++; $display("FAIL en_di_acpt cyc=%0d got=%b exp=0", i, di_acpt); end
         if (i > 0) begin
            checks++; if (do_rdy !== 1'b0) begin errors++; $display("FAIL en_drain cyc=%0d got=%b exp=0", i, do_rdy); end
         end
         step();
      end
      checks++; if (n_in !== n_before) begin errors++; $display("FAIL en_no_input got=%0d exp=%0d", n_in, n_before); end
      enable = 1'b1; target = n_in + 60;
      for (int c = 0; c < 200 && n_in < target; c++) begin di_data = 8'(n_in + 1); step(); end
      di_rdy = 1'b0;
      repeat (3) step();
      while (sb_pop(e, g)) if (e.chk) begin
         checks++;
         if (g !== e.val) begin errors++; $display("FAIL sb_en idx=%0d got=%h exp=%h", e.idx, g, e.val); end
      end
      checks++; if (n_out !== n_in) begin errors++; $display("FAIL en_count got=%0d exp=%0d", n_out, n_in); end
   endtask

   task automatic test_chain();
      exp_t e; logic [7:0] g; logic [7:0] sync;
      reset_n = 1'b0; #1; @(negedge clk); reset_n = 1'b1; sb_clear();
      mode = 1; build_chain();
      for (int c = 0; c < 20000 && n_in < 3000; c++) begin
         di_rdy  = ($urandom_range(0, 3) != 0);
         do_acpt = ($urandom_range(0, 3) != 0);
         di_data = ilv[n_in];
         step();
         while (sb_pop(e, g)) if (e.chk) begin
            checks++;
            if (g !== e.val) begin errors++; $display("FAIL sb_chain idx=%0d got=%h exp=%h", e.idx, g, e.val); end
            if ((e.idx - DLY) % 204 == 0) begin
               sync = (((e.idx - DLY) / 204) % 8 == 0) ? 8'hB8 : 8'h47;
               checks++;
               if (g !== sync) begin errors++; $display("FAIL chain_sync idx=%0d got=%h exp=%h", e.idx, g, sync); end
            end
         end
      end
      checks++; if (n_in < 3000) begin errors++; $display("FAIL chain_timeout got=%0d exp=3000", n_in); end
   endtask

   task automatic test_reset_mid();
      exp_t e; logic [7:0] g;
      di_rdy = 1'b1; do_acpt = 1'b1; di_data = ilv[n_in];
      step();
      reset_n = 1'b0;
      #1;
      checks++; if (do_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_do_rdy got=%b exp=0", do_rdy); end
      checks++; if (di_acpt !== 1'b0) begin errors++; $display("FAIL mid_reset_di_acpt got=%b exp=0", di_acpt); end
      checks++; if (primed !== 1'b0) begin errors++; $display("FAIL mid_reset_primed got=%b exp=0", primed); end
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1; sb_clear(); mode = 1;
      for (int c = 0; c < 3000 && n_in < 2400; c++) begin
         di_data = ilv[n_in];
         step();
         if (n_in == DLY - 1) begin
            checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reprime_early got=%b exp=0", primed); end
         end
         if (n_in == DLY) begin
            checks++; if (primed !== 1'b1) begin errors++; $display("FAIL reprime_rise got=%b exp=1", primed); end
         end
         while (sb_pop(e, g)) if (e.chk) begin
            checks++;
            if (g !== e.val) begin errors++; $display("FAIL sb_reprime idx=%0d got=%h exp=%h", e.idx, g, e.val); end
         end
      end
      checks++; if (n_in < 2400) begin errors++; $display("FAIL reprime_timeout got=%0d exp=2400", n_in); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_passthrough();
      test_stream();
      test_backpressure();
      test_enable();
      test_chain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
